// File: rtl/maze_mem_arbiter_if.sv
// Bundle between the two maze-memory requesters, the arbiter and the memory pins.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface maze_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 1
);
    // Handshake: reqN is held high with wrN/addrN/wdataN stable until a cycle in
    // which gntN is high; that cycle is the accepted beat. rvalidN is high exactly
    // one cycle after each accepted read beat of port N, with rdataN carrying the word.
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_cen;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_cen, mem_wr, mem_rd, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_cen, mem_wr, mem_rd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the single-port maze memory
// between the rat solver (port 0) and the loader/path-display engine (port 1).
module maze_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    maze_mem_arbiter_if.slave    bus,
    output logic [1:0]           state_o
);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    state_e            state_q;
    logic              last_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic              burst_done;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              gnt0_c;
    logic              gnt1_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign gnt0_c = (state_q == G0) && bus.req0;
    assign gnt1_c = (state_q == G1) && bus.req1;

    assign beat_d     = (beat_q == BEAT_W'(MAX_BURST)) ? beat_q : beat_q + 1'b1;
    assign burst_done = (beat_q == BEAT_W'(MAX_BURST - 1));

    // Memory pins follow the granted port and are all zero whenever no beat is accepted.
    always_comb begin
        bus.mem_cen = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.mem_rd  = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (gnt0_c) begin
            bus.mem_cen = 1'b1;
            bus.mem_wr  = bus.wr0;
            bus.mem_rd  = ~bus.wr0;
            mem_addr_c  = bus.addr0;
            mem_wdata_c = bus.wdata0;
        end else if (gnt1_c) begin
            bus.mem_cen = 1'b1;
            bus.mem_wr  = bus.wr1;
            bus.mem_rd  = ~bus.wr1;
            mem_addr_c  = bus.addr1;
            mem_wdata_c = bus.wdata1;
        end
    end

    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;

    // A read return already in flight when reset is asserted is suppressed.
    assign bus.rvalid0 = rvalid0_q & ~rst;
    assign bus.rvalid1 = rvalid1_q & ~rst;
    assign bus.rdata0  = bus.mem_rdata;
    assign bus.rdata1  = bus.mem_rdata;

    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            beat_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0_c & ~bus.wr0;
            rvalid1_q <= gnt1_c & ~bus.wr1;
            case (state_q)
                IDLE: begin
                    // On a tie the port that was not granted last wins.
                    if (bus.req0 && (!bus.req1 || last_q)) begin
                        state_q <= G0;
                        last_q  <= 1'b0;
                        beat_q  <= '0;
                    end else if (bus.req1) begin
                        state_q <= G1;
                        last_q  <= 1'b1;
                        beat_q  <= '0;
                    end
                end
                G0: begin
                    if (!bus.req0) begin
                        if (bus.req1) begin
                            state_q <= G1;
                            last_q  <= 1'b1;
                            beat_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (burst_done && bus.req1) begin
                        state_q <= G1;
                        last_q  <= 1'b1;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_d;
                    end
                end
                G1: begin
                    if (!bus.req1) begin
                        if (bus.req0) begin
                            state_q <= G0;
                            last_q  <= 1'b0;
                            beat_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (burst_done && bus.req0) begin
                        state_q <= G0;
                        last_q  <= 1'b0;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter: expected beats and read returns are queued
// with their cycle numbers and checked by an independent monitor.
module tb_maze_mem_arbiter;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 1;
    localparam int MAX_BURST = 4;
    localparam int BEAT_W    = 43;
    localparam int RD_W      = 34;

    typedef struct packed {
        logic [31:0] cyc;
        logic        port;
        logic        wr;
        logic [7:0]  addr;
        logic        wd;
    } beat_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        port;
        logic        data;
    } rd_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    logic mon_en = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maze_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic [1:0] state;

    maze_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .state_o(state)
    );

    // synchronous-read memory: only 0x11 and 0x23 hold 1 after preload
    logic mem [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 'h11 || i == 'h23);
        end else if (bus.mem_cen) begin
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // scoreboard
    logic [BEAT_W-1:0] exp_q[$];
    logic [RD_W-1:0]   exp_rd_q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_beat(input int c, input logic p, input logic w,
                             input logic [7:0] a, input logic d);
        beat_t b;
        b.cyc = c; b.port = p; b.wr = w; b.addr = a; b.wd = d;
        exp_q.push_back(b);
    endtask

    task automatic push_rd(input int c, input logic p, input logic d);
        rd_t r;
        r.cyc = c; r.port = p; r.data = d;
        exp_rd_q.push_back(r);
    endtask

    // monitor
    beat_t mb;
    rd_t   mr;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.gnt0 || bus.gnt1) begin
                chk("gnt_onehot", int'(bus.gnt0 & bus.gnt1), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", int'({bus.gnt1, bus.gnt0}), 0);
                end else begin
                    mb = exp_q.pop_front();
                    chk("gnt_cycle", cyc, int'(mb.cyc));
                    chk("gnt_port", int'(bus.gnt1), int'(mb.port));
                    chk("mem_cen", int'(bus.mem_cen), 1);
                    chk("mem_wr", int'(bus.mem_wr), int'(mb.wr));
                    chk("mem_rd", int'(bus.mem_rd), int'(!mb.wr));
                    chk("mem_addr", int'(bus.mem_addr), int'(mb.addr));
                    chk("mem_wdata", int'(bus.mem_wdata), int'(mb.wd));
                end
            end else begin
                chk("idle_mem_pins",
                    int'({bus.mem_cen, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata}), 0);
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                chk("rvalid_onehot", int'(bus.rvalid0 & bus.rvalid1), 0);
                if (exp_rd_q.size() == 0) begin
                    chk("unexpected_rvalid", int'({bus.rvalid1, bus.rvalid0}), 0);
                end else begin
                    mr = exp_rd_q.pop_front();
                    chk("rvalid_cycle", cyc, int'(mr.cyc));
                    chk("rvalid_port", int'(bus.rvalid1), int'(mr.port));
                    chk("rdata", int'(bus.rvalid1 ? bus.rdata1 : bus.rdata0), int'(mr.data));
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic d);
        bus.req0 = r; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic d);
        bus.req1 = r; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
    endtask

    initial begin
        int c;
        set0(1'b0, 1'b0, 8'h00, 1'b0);
        set1(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        preload = 1'b0;
        tick();
        rst = 1'b0;
        chk("reset_state", int'(state), 0);
        chk("reset_gnt", int'({bus.gnt1, bus.gnt0}), 0);
        chk("reset_rvalid", int'({bus.rvalid1, bus.rvalid0}), 0);
        chk("reset_mem_pins", int'({bus.mem_cen, bus.mem_wr, bus.mem_rd, bus.mem_addr}), 0);
        mon_en = 1'b1;

        // single read of 0x23 by port 0 from idle
        tick();
        c = cyc;
        set0(1'b1, 1'b0, 8'h23, 1'b0);
        push_beat(c + 1, 1'b0, 1'b0, 8'h23, 1'b0);
        push_rd(c + 2, 1'b0, 1'b1);
        ticks(2);
        set0(1'b0, 1'b0, 8'h00, 1'b0);
        ticks(3);

        // fresh reset, then both ports contend: 4 beats each, port 0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c = cyc;
        set0(1'b1, 1'b0, 8'h11, 1'b0);
        set1(1'b1, 1'b0, 8'h40, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            push_beat(c + i, 1'b0, 1'b0, 8'h11, 1'b0);
            push_rd(c + i + 1, 1'b0, 1'b1);
        end
        for (int i = 5; i <= 8; i++) begin
            push_beat(c + i, 1'b1, 1'b0, 8'h40, 1'b0);
            push_rd(c + i + 1, 1'b1, 1'b0);
        end
        for (int i = 9; i <= 10; i++) begin
            push_beat(c + i, 1'b0, 1'b0, 8'h11, 1'b0);
            push_rd(c + i + 1, 1'b0, 1'b1);
        end
        ticks(11);
        set0(1'b0, 1'b0, 8'h00, 1'b0);
        set1(1'b0, 1'b0, 8'h00, 1'b0);
        ticks(3);

        // port 1 alone writes 0x5A ten times, then reads it back
        c = cyc;
        set1(1'b1, 1'b1, 8'h5A, 1'b1);
        for (int i = 1; i <= 10; i++) push_beat(c + i, 1'b1, 1'b1, 8'h5A, 1'b1);
        ticks(11);
        set1(1'b1, 1'b0, 8'h5A, 1'b0);
        push_beat(c + 11, 1'b1, 1'b0, 8'h5A, 1'b0);
        push_rd(c + 12, 1'b1, 1'b1);
        tick();
        set1(1'b0, 1'b0, 8'h00, 1'b0);
        ticks(3);

        // port 0 releases mid-burst while port 1 waits: one idle cycle, then port 1
        c = cyc;
        set0(1'b1, 1'b0, 8'h23, 1'b0);
        push_beat(c + 1, 1'b0, 1'b0, 8'h23, 1'b0);
        push_beat(c + 2, 1'b0, 1'b0, 8'h23, 1'b0);
        push_rd(c + 2, 1'b0, 1'b1);
        push_rd(c + 3, 1'b0, 1'b1);
        tick();
        set1(1'b1, 1'b0, 8'h5A, 1'b0);
        ticks(2);
        set0(1'b0, 1'b0, 8'h00, 1'b0);
        push_beat(c + 4, 1'b1, 1'b0, 8'h5A, 1'b0);
        push_beat(c + 5, 1'b1, 1'b0, 8'h5A, 1'b0);
        push_rd(c + 5, 1'b1, 1'b1);
        push_rd(c + 6, 1'b1, 1'b1);
        ticks(3);
        set1(1'b0, 1'b0, 8'h00, 1'b0);
        ticks(3);

        // reset during a port-1 read burst: return dropped, next tie to port 0
        c = cyc;
        set1(1'b1, 1'b0, 8'h40, 1'b0);
        push_beat(c + 1, 1'b1, 1'b0, 8'h40, 1'b0);
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1'b1, 1'b0, 8'h23, 1'b0);
        chk("rst_mid_state", int'(state), 0);
        push_beat(c + 4, 1'b0, 1'b0, 8'h23, 1'b0);
        push_rd(c + 5, 1'b0, 1'b1);
        ticks(2);
        set0(1'b0, 1'b0, 8'h00, 1'b0);
        set1(1'b0, 1'b0, 8'h00, 1'b0);
        ticks(4);

        chk("beat_queue_drained", exp_q.size(), 0);
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
